display_scanner: RTL and testbench

//  Time-multiplexes a NUM_DIGITS-digit common-anode seven-segment display.
//  - Selects one digit slot at a time and presents its nibble and decimal-point flag on digit_out/decimal_out.
//  - These outputs feed the seven-segment decoder directly.
//  - Drives the active-low anode enables.
//  - Latches the display value once per frame to prevent tearing.
//  - Optionally suppresses leading zeros using the decoder's space code.

---
 rtl/display_pkg.sv | 19 +
 rtl/display_scanner_prescaler.sv | 40 ++++
 rtl/display_scanner.sv | 120 ++++++++++++
 tb/tb_display_scanner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the seven-segment display scanner
package display_pkg;

    localparam int DEFAULT_NUM_DIGITS = 4;
    localparam int MAX_DIGITS = 8;

    // Space code understood by the seven-segment decoder
    localparam logic [3:0] BLANK_CODE = 4'hD;

    function automatic logic [MAX_DIGITS-1:0] anodes_off(input int n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// rtl/display_scanner_prescaler.sv - per-slot cycle counter with wrap strobe and gap flag
module scan_prescaler #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic slot_adv,
    output logic in_gap
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // in_gap describes the count being loaded on this edge, so the
    // registered anode outputs line up with the prescaler without lag.
    always_comb begin
        slot_adv = enable && (count == LAST);
        if (!enable || slot_adv) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(1);
        end
        in_gap = (count_next < GAP_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed common-anode seven-segment scanner with frame latch and zero blanking
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [3:0]              digit_out,
    output logic                    decimal_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] OFF_WIDE = anodes_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = OFF_WIDE[NUM_DIGITS-1:0];

    logic slot_adv;
    logic in_gap;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .slot_adv(slot_adv),
        .in_gap  (in_gap)
    );

    logic [SW-1:0]           slot, slot_next;
    logic [4*NUM_DIGITS-1:0] sh_value, sh_value_next;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_next;
    // lz_blank is folded into the stored suppression mask
    logic [NUM_DIGITS-1:0]   sh_supp, sh_supp_next;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    latch;
    logic                    wrap;
    logic [3:0]              sel_nibble;
    logic                    sel_dp;
    logic                    sel_supp;

    always_comb begin
        logic lead;
        lead = 1'b1;
        lz_mask = '0;
        for (int s = NUM_DIGITS - 1; s >= 1; s--) begin
            if (value[4*s +: 4] != 4'h0 || dp_mask[s]) lead = 1'b0;
            lz_mask[s] = lead;
        end
    end

    always_comb begin
        wrap  = slot_adv && (slot == LAST_SLOT);
        latch = !enable || wrap;

        if (!enable || wrap) begin
            slot_next = '0;
        end else if (slot_adv) begin
            slot_next = slot + SW'(1);
        end else begin
            slot_next = slot;
        end

        // Slot 0 of a new frame must come from the freshly latched inputs
        if (latch) begin
            sh_value_next = value;
            sh_dp_next    = dp_mask;
            sh_supp_next  = lz_blank ? lz_mask : '0;
        end else begin
            sh_value_next = sh_value;
            sh_dp_next    = sh_dp;
            sh_supp_next  = sh_supp;
        end

        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_supp   = 1'b0;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (slot_next == SW'(s)) begin
                sel_nibble = sh_value_next[4*s +: 4];
                sel_dp     = sh_dp_next[s];
                sel_supp   = sh_supp_next[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot        <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_supp     <= '0;
            anode_n     <= ALL_OFF;
            digit_out   <= BLANK_CODE;
            decimal_out <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            slot        <= slot_next;
            sh_value    <= sh_value_next;
            sh_dp       <= sh_dp_next;
            sh_supp     <= sh_supp_next;
            anode_n     <= (!enable || in_gap) ? ALL_OFF
                                               : ~(NUM_DIGITS'(1) << slot_next);
            digit_out   <= sel_supp ? BLANK_CODE : sel_nibble;
            decimal_out <= !sel_supp && sel_dp;
            frame_tick  <= enable && wrap;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner
module tb_display_scanner;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit_out;
    logic        decimal_out;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int passed = 0;
    int total = 0;

    display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .digit_out  (digit_out),
        .decimal_out(decimal_out),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: t counts cycles since the scan (re)started at slot 0, prescaler 0
    int          t = 0;
    bit          m_rst = 1'b1;
    bit          m_tick = 1'b0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    bit          m_lz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rst = 1'b1; t = 0; m_tick = 1'b0;
            m_val = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
        end else begin
            m_rst = 1'b0;
            if (!enable) begin
                t = 0; m_tick = 1'b0;
                m_val = value; m_dp = dp_mask; m_lz = lz_blank;
            end else begin
                t++;
                m_tick = (t % FRAME == 0);
                if (m_tick) begin
                    m_val = value; m_dp = dp_mask; m_lz = lz_blank;
                end
            end
        end
    end

    function automatic int cur_slot();
        return (t / DIV) % N;
    endfunction

    // A slot is blank when it and every slot to its left are zero with no dp
    function automatic bit suppressed(input int s);
        return m_lz && (s != 0) && ((m_val >> (4 * s)) == 16'h0) && ((m_dp >> s) == 4'h0);
    endfunction

    function automatic logic [3:0] exp_digit();
        int s;
        if (m_rst) return 4'hD;
        s = cur_slot();
        if (suppressed(s)) return 4'hD;
        return 4'((m_val >> (4 * s)) & 16'hF);
    endfunction

    function automatic logic exp_dec();
        int s;
        if (m_rst) return 1'b0;
        s = cur_slot();
        return !suppressed(s) && m_dp[s];
    endfunction

    function automatic logic [3:0] exp_anode();
        if (m_rst || (t % DIV) < BLANK) return 4'hF;
        return ~(4'b0001 << cur_slot());
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("model_anode_n", 16'(anode_n), 16'(exp_anode()));
        check("model_digit_out", 16'(digit_out), 16'(exp_digit()));
        check("model_decimal_out", 16'(decimal_out), 16'(exp_dec()));
        check("model_frame_tick", 16'(frame_tick), 16'(m_tick));
    end

    task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic l);
        value = v; dp_mask = d; lz_blank = l; enable = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] dig_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int nticks;

    initial begin
        // Scan of 1234: first frame is the zero reset shadow, second shows 4,3,2,1
        restart(16'h1234, 4'h0, 1'b0);
        cycles(1);
        check("frame1_digit", 16'(digit_out), 16'h0);
        cycles(15);
        check("latch_tick", 16'(frame_tick), 16'h1);
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 4; p++) begin
                if (!(s == 0 && p == 0)) cycles(1);
                check("scan_anode", 16'(anode_n), 16'((p == 0) ? 4'hF : an_tab[s]));
                check("scan_digit", 16'(digit_out), 16'(dig_tab[s]));
            end
        end

        // Reset at slot 2, prescaler 3
        cycles(12);
        check("pre_reset_anode", 16'(anode_n), 16'(4'b1011));
        check("pre_reset_digit", 16'(digit_out), 16'h2);
        #2 reset = 1'b1;
        #1;
        check("rst_anode", 16'(anode_n), 16'hF);
        check("rst_digit", 16'(digit_out), 16'hD);
        check("rst_dec", 16'(decimal_out), 16'h0);
        check("rst_tick", 16'(frame_tick), 16'h0);

        // Leading-zero suppression of 0050, then with dp on slot 2
        restart(16'h0050, 4'h0, 1'b1);
        cycles(17);
        check("lz_s0", 16'(digit_out), 16'h0);
        cycles(4);
        check("lz_s1", 16'(digit_out), 16'h5);
        cycles(4);
        check("lz_s2", 16'(digit_out), 16'hD);
        check("lz_s2_dp", 16'(decimal_out), 16'h0);
        cycles(4);
        check("lz_s3", 16'(digit_out), 16'hD);
        dp_mask = 4'b0100;
        cycles(12);
        check("lzdp_s2", 16'(digit_out), 16'h0);
        check("lzdp_s2_dp", 16'(decimal_out), 16'h1);
        check("lzdp_s2_anode", 16'(anode_n), 16'(4'b1011));
        cycles(4);
        check("lzdp_s3", 16'(digit_out), 16'hD);

        // Mid-frame input change stays hidden until the next latch
        restart(16'h1111, 4'h0, 1'b0);
        cycles(21);
        check("tear_s1_before", 16'(digit_out), 16'h1);
        value = 16'h2222;
        cycles(4);
        check("tear_s2", 16'(digit_out), 16'h1);
        cycles(4);
        check("tear_s3", 16'(digit_out), 16'h1);
        cycles(3);
        check("tear_tick", 16'(frame_tick), 16'h1);
        check("tear_new_s0", 16'(digit_out), 16'h2);
        nticks = 0;
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            if (frame_tick) nticks++;
        end
        check("tick_count_32cyc", 16'(nticks), 16'd2);
        cycles(1);
        check("tear_after_anode", 16'(anode_n), 16'(4'b1110));
        check("tear_after_digit", 16'(digit_out), 16'h2);

        // Enable low for 10 cycles mid-frame
        restart(16'h1234, 4'h0, 1'b0);
        cycles(22);
        enable = 1'b0;
        value = 16'h5678;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("dis_anode", 16'(anode_n), 16'hF);
            check("dis_tick", 16'(frame_tick), 16'h0);
        end
        enable = 1'b1;
        check("reen_gap_digit", 16'(digit_out), 16'h8);
        cycles(1);
        check("reen_anode", 16'(anode_n), 16'(4'b1110));
        check("reen_digit", 16'(digit_out), 16'h8);
        cycles(4);
        check("reen_s1_anode", 16'(anode_n), 16'(4'b1101));
        check("reen_s1_digit", 16'(digit_out), 16'h7);

        // All-zero value with suppression
        restart(16'h0000, 4'h0, 1'b1);
        cycles(17);
        check("zero_s0", 16'(digit_out), 16'h0);
        cycles(4);
        check("zero_s1", 16'(digit_out), 16'hD);
        check("zero_s1_anode", 16'(anode_n), 16'(4'b1101));
        cycles(4);
        check("zero_s2", 16'(digit_out), 16'hD);
        cycles(4);
        check("zero_s3", 16'(digit_out), 16'hD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
